// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RISC-V style decode stage: register file, field/immediate decode, one-entry output hold
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic            wb_commit;
    logic            capture;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;
    logic [31:0]     imm32;
    logic            known;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            reg_bad;
    logic            dec_illegal;

    assign wb_commit = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < 6'(NREG));
    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready && !flush;

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
        if (a == 5'd0 || !({1'b0, a} < 6'(NREG)))
            return '0;
        if (BYPASS != 0 && wb_commit && wb_addr == a)
            return wb_data;
        return regs[a[AW-1:0]];
    endfunction

    always_comb begin
        rd1_val = read_reg(inst[19:15]);
        rd2_val = read_reg(inst[24:20]);
    end

    always_comb begin
        imm32   = '0;
        known   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                imm32   = {{20{inst[31]}}, inst[31:20]};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            7'b0100011: begin
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1100011: begin
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                imm32  = {inst[31:12], 12'b0};
                use_rd = 1'b1;
            end
            7'b1101111: begin
                imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                use_rd = 1'b1;
            end
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // Only RV32E-sized files reject the upper half of the register namespace.
        reg_bad = (NREG == 16) &&
                  ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]));
        dec_illegal = (inst[1:0] != 2'b11) || !known || reg_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_commit) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            imm       <= '0;
            opcode    <= '0;
            func3     <= '0;
            func7     <= '0;
            rd        <= '0;
            rs1_addr  <= '0;
            rs2_addr  <= '0;
            pc_out    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            rs1_data  <= rd1_val;
            rs2_data  <= rd2_val;
            imm       <= XLEN'($signed(imm32));
            opcode    <= inst[6:0];
            func3     <= inst[14:12];
            func7     <= inst[31:25];
            rd        <= inst[11:7];
            rs1_addr  <= inst[19:15];
            rs2_addr  <= inst[24:20];
            pc_out    <= pc;
            illegal   <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // A stalled bundle must not go stale when its sources are rewritten.
            if (wb_commit && wb_addr == rs1_addr)
                rs1_data <= wb_data;
            if (wb_commit && wb_addr == rs2_addr)
                rs2_data <= wb_data;
        end
    end

endmodule
